// File: rtl/i2s_audio_tx_if.sv
// Audio-side and I2S pin bundle for the I2S transmitter.
// The master modport is the transmitter; the slave modport is its environment.
interface i2s_audio_tx_if;
   logic [15:0] audio_l;
   logic [15:0] audio_r;
   logic        mute;
   logic        sample_req;
   logic        i2s_bck;
   logic        i2s_lrck;
   logic        i2s_data;

   modport master (
      input  audio_l, audio_r, mute,
      output sample_req, i2s_bck, i2s_lrck, i2s_data
   );

   modport slave (
      output audio_l, audio_r, mute,
      input  sample_req, i2s_bck, i2s_lrck, i2s_data
   );
endinterface

// File: rtl/i2s_audio_tx.sv
// Master-mode Philips I2S serializer for 16-bit stereo audio.
// Generates BCK/LRCK from clk and latches one stereo sample per 32-BCK frame.
module i2s_audio_tx #(
   parameter int BCK_DIV   = 8,
   parameter int SIGNED_IN = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   i2s_audio_tx_if.master        bus
);
   localparam logic [7:0]  DIV_LAST = 8'(BCK_DIV - 1);
   localparam logic [15:0] MSB_FLIP = (SIGNED_IN == 0) ? 16'h8000 : 16'h0000;

   logic [7:0]  div_cnt;
   logic [4:0]  slot;
   logic [15:0] shadow_l;
   logic [15:0] shadow_r;
   logic        bck_q;
   logic        lrck_q;
   logic        data_q;
   logic        req_q;

   logic        div_wrap;
   logic        fall_evt;
   logic [4:0]  slot_nxt;
   logic        frame_start;
   logic [15:0] load_l;
   logic [15:0] load_r;
   logic [15:0] cur_l;
   logic [15:0] cur_r;
   logic        data_nxt;
   logic        lrck_nxt;

   always_comb begin
      div_wrap    = (div_cnt == DIV_LAST);
      fall_evt    = div_wrap && bck_q;
      slot_nxt    = slot + 5'd1;
      frame_start = (slot_nxt == 5'd0);
      // Mute loads true two's-complement silence, so no MSB flip applies to it.
      load_l      = bus.mute ? 16'h0000 : (bus.audio_l ^ MSB_FLIP);
      load_r      = bus.mute ? 16'h0000 : (bus.audio_r ^ MSB_FLIP);
      cur_l       = frame_start ? load_l : shadow_l;
      cur_r       = frame_start ? load_r : shadow_r;
      // 15-s for the left half and 31-s for the right half both reduce to ~s[3:0].
      data_nxt    = slot_nxt[4] ? cur_r[~slot_nxt[3:0]] : cur_l[~slot_nxt[3:0]];
      lrck_nxt    = (slot_nxt >= 5'd15) && (slot_nxt <= 5'd30);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_cnt  <= 8'd0;
         slot     <= 5'd31;
         shadow_l <= 16'h0000;
         shadow_r <= 16'h0000;
         bck_q    <= 1'b0;
         lrck_q   <= 1'b0;
         data_q   <= 1'b0;
         req_q    <= 1'b0;
      end else begin
         req_q <= 1'b0;
         if (div_wrap) begin
            div_cnt <= 8'd0;
            bck_q   <= ~bck_q;
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
         if (fall_evt) begin
            slot   <= slot_nxt;
            data_q <= data_nxt;
            lrck_q <= lrck_nxt;
            if (frame_start) begin
               shadow_l <= load_l;
               shadow_r <= load_r;
               req_q    <= 1'b1;
            end
         end
      end
   end

   assign bus.sample_req = req_q;
   assign bus.i2s_bck    = bck_q;
   assign bus.i2s_lrck   = lrck_q;
   assign bus.i2s_data   = data_q;
endmodule
